// File: rtl/shift_exec_unit.sv
// shift_exec_unit: multi-cycle shift/rotate execution stage.
//
// The unit takes one request, then resolves its shift amount one binary stage
// per cycle (by 1, 2, 4, ... 2^(AMT_W-1)). The result is ready a fixed AMT_W
// cycles after the request is accepted, whatever the amount. The result comes
// back with carry, zero and negative flags and is held until it is consumed.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clr                synchronous flush; drops any operation and returns to idle
//   in_valid/in_ready  request handshake (in_ready is high only while idle)
//   in_data            operand
//   in_amt             unsigned shift amount
//   in_op              000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, others PASS
//   out_valid/out_ready result handshake; the result is held while stalled
//   out_data           result
//   out_carry          last bit shifted or rotated out
//   out_zero           out_data == 0
//   out_neg            out_data MSB
module shift_exec_unit #(
    parameter int DATA_W = 16,
    parameter int AMT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [2:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_carry,
    output logic              out_zero,
    output logic              out_neg
);
    localparam int CNT_W = $clog2(AMT_W);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(AMT_W - 1);

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic [AMT_W-1:0] amt;
        logic [2:0]       op;
    } req_t;

    state_t            state, state_nxt;
    req_t              req_q;
    logic [DATA_W-1:0] work;
    logic              work_c;
    logic [CNT_W-1:0]  cnt;

    // Per-stage datapath
    logic [AMT_W-1:0]  sh;
    logic [IDX_W-1:0]  idx_l, idx_r;
    logic [DATA_W-1:0] lsl, lsr, asr, rol, ror;
    logic [DATA_W-1:0] stg_data;
    logic              stg_c;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        sh    = AMT_W'(1) << cnt;
        // Index of the last bit to leave the word. The IDX_W-bit wrap makes
        // a full-width shift select bit 0 (left) or bit DATA_W-1 (right).
        idx_l = IDX_W'(0) - sh[IDX_W-1:0];
        idx_r = sh[IDX_W-1:0] - IDX_W'(1);
        lsl   = work << sh;
        lsr   = work >> sh;
        asr   = $signed(work) >>> sh;
        // A full-width rotate gives back the word unchanged: one term is 0 and
        // the other is the word shifted by 0.
        rol   = (work << sh) | (work >> (DATA_W - int'(sh)));
        ror   = (work >> sh) | (work << (DATA_W - int'(sh)));

        stg_data = work;
        stg_c    = work_c;
        // Chaining the stages leaves the carry as the last bit to exit over the
        // whole shift. That bit is 0 once a zero-filled shift passes the width,
        // and it is the sign once an ASR passes the width.
        if (req_q.amt[cnt]) begin
            case (req_q.op)
                OP_LSL: begin stg_data = lsl; stg_c = work[idx_l]; end
                OP_LSR: begin stg_data = lsr; stg_c = work[idx_r]; end
                OP_ASR: begin stg_data = asr; stg_c = work[idx_r]; end
                OP_ROL: begin stg_data = rol; stg_c = rol[0]; end
                OP_ROR: begin stg_data = ror; stg_c = ror[DATA_W-1]; end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) state_nxt = BUSY;
                BUSY: if (cnt == LAST) state_nxt = DONE;
                DONE: if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_q     <= '0;
            work      <= '0;
            work_c    <= 1'b0;
            cnt       <= '0;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
            out_neg   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clr) begin
                cnt <= '0;
            end else begin
                case (state)
                    IDLE: if (in_valid) begin
                        work      <= in_data;
                        work_c    <= 1'b0;
                        req_q.amt <= in_amt;
                        req_q.op  <= in_op;
                        cnt       <= '0;
                    end
                    BUSY: begin
                        work   <= stg_data;
                        work_c <= stg_c;
                        cnt    <= cnt + CNT_W'(1);
                        // The output registers change only when a result is
                        // complete. A flushed operation leaves them untouched.
                        if (cnt == LAST) begin
                            cnt       <= '0;
                            out_data  <= stg_data;
                            out_carry <= stg_c;
                            out_zero  <= (stg_data == '0);
                            out_neg   <= stg_data[DATA_W-1];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
